visited_store: RTL and testbench



---
 rtl/visited_store.sv | 103 ++++++++++
 tb/tb_visited_store.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/visited_store.sv
`default_nettype none
// ============================================================================
// Module   : visited_store
// Purpose  : Per-node visited bookkeeping for the shortest-path engine.
//            Holds one predecessor ("prev") entry per node slot, a visited
//            bit per slot and a count of active nodes not yet visited.
//            Writing a slot's predecessor marks that node visited. The
//            first visit to a slot decrements the count; later visits only
//            overwrite prev.
// Ports    : reset                 - synchronous active-high reset
//            clock                 - rising-edge clock
//            set_en                - visit/write strobe
//            number_of_nodes       - active node count, captured at reset
//            index                 - node being visited
//            prev_node             - predecessor recorded for index
//            unvisited_nodes       - registered count of unvisited nodes
//            prev_vector_flattened - registered prev entries, entry j at
//                                    [INDEX_WIDTH*j +: INDEX_WIDTH]
// Revision : 1.0 - initial release
// ============================================================================

`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif

module visited_store #(
    parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
) (
    input  logic                           reset,
    input  logic                           clock,
    input  logic                           set_en,
    input  logic [INDEX_WIDTH-1:0]         number_of_nodes,
    input  logic [INDEX_WIDTH-1:0]         index,
    input  logic [INDEX_WIDTH-1:0]         prev_node,
    output logic [INDEX_WIDTH-1:0]         unvisited_nodes,
    output logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened
);

    // All-ones marks a prev entry that has never been written.
    localparam logic [INDEX_WIDTH-1:0] c_UNVISITED = '1;

    // VALUE_WIDTH only keeps the parameter list aligned with the sibling
    // distance store; this empty block gives it a reference.
    if (VALUE_WIDTH > 0) begin : g_value_width_ref
    end

    logic [INDEX_WIDTH-1:0] r_prev [MAX_NODES];
    logic [MAX_NODES-1:0]   r_visited;
    logic [INDEX_WIDTH-1:0] r_unvisited;
    // Active node count frozen at reset; later changes on the input port
    // must not move the visit range until the next reset.
    logic [INDEX_WIDTH-1:0] r_num_nodes;

    logic                   w_in_range;
    logic [MAX_NODES-1:0]   w_hit;
    logic                   w_new_visit;

    assign w_in_range = (index < r_num_nodes) &&
                        ({{(32-INDEX_WIDTH){1'b0}}, index} < 32'(MAX_NODES));

    // One-hot slot select; at most one bit set since index matches one j.
    for (genvar j = 0; j < MAX_NODES; j++) begin : g_slot
        assign w_hit[j] = set_en && w_in_range && (index == INDEX_WIDTH'(j));

        always_ff @(posedge clock) begin
            if (reset) begin
                r_prev[j]    <= c_UNVISITED;
                r_visited[j] <= 1'b0;
            end else if (w_hit[j]) begin
                r_prev[j]    <= prev_node;
                r_visited[j] <= 1'b1;
            end
        end

        assign prev_vector_flattened[INDEX_WIDTH*j +: INDEX_WIDTH] = r_prev[j];
    end

    // Visited status comes from the visited bit, so a prev_node equal to the
    // unvisited marker still counts as a real visit.
    assign w_new_visit = |(w_hit & ~r_visited);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_unvisited <= number_of_nodes;
            r_num_nodes <= number_of_nodes;
        end else if (w_new_visit && (r_unvisited != '0)) begin
            r_unvisited <= r_unvisited - 1'b1;
        end
    end

    assign unvisited_nodes = r_unvisited;

endmodule

`default_nettype wire

// File: tb/tb_visited_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_visited_store
// Purpose  : Self-checking bench for visited_store. Directed scenarios plus
//            randomized visits/resets are compared every cycle against an
//            array-based reference model of the bookkeeping rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_visited_store;

    localparam int MAX_NODES   = 16;
    localparam int INDEX_WIDTH = 8;
    localparam int VALUE_WIDTH = 16;
    localparam int VEC_W       = INDEX_WIDTH * MAX_NODES;
    localparam logic [INDEX_WIDTH-1:0] c_UNV = '1;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   set_en;
    logic [INDEX_WIDTH-1:0] number_of_nodes;
    logic [INDEX_WIDTH-1:0] index;
    logic [INDEX_WIDTH-1:0] prev_node;
    logic [INDEX_WIDTH-1:0] unvisited_nodes;
    logic [VEC_W-1:0]       prev_vector_flattened;

    visited_store #(
        .MAX_NODES  (MAX_NODES),
        .INDEX_WIDTH(INDEX_WIDTH),
        .VALUE_WIDTH(VALUE_WIDTH)
    ) u_dut (
        .reset                (reset),
        .clock                (clock),
        .set_en               (set_en),
        .number_of_nodes      (number_of_nodes),
        .index                (index),
        .prev_node            (prev_node),
        .unvisited_nodes      (unvisited_nodes),
        .prev_vector_flattened(prev_vector_flattened)
    );

    always #5 clock = ~clock;

    // Reference model state
    int m_prev    [MAX_NODES];
    bit m_visited [MAX_NODES];
    int m_count;
    int m_active;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic chk(input string tag, input logic [VEC_W-1:0] obs,
                       input logic [VEC_W-1:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [VEC_W-1:0] model_vec();
        logic [VEC_W-1:0] v;
        for (int j = 0; j < MAX_NODES; j++)
            v[INDEX_WIDTH*j +: INDEX_WIDTH] = INDEX_WIDTH'(m_prev[j]);
        return v;
    endfunction

    // Apply one cycle of inputs, advance the model by the rules, compare.
    task automatic step(input string tag, input bit rst, input bit en,
                        input int nn, input int idx, input int pn);
        reset           = rst;
        set_en          = en;
        number_of_nodes = INDEX_WIDTH'(nn);
        index           = INDEX_WIDTH'(idx);
        prev_node       = INDEX_WIDTH'(pn);
        @(posedge clock);
        if (rst) begin
            for (int j = 0; j < MAX_NODES; j++) begin
                m_prev[j]    = int'(c_UNV);
                m_visited[j] = 0;
            end
            m_count  = nn;
            m_active = nn;
        end else if (en && idx < m_active && idx < MAX_NODES) begin
            m_prev[idx] = pn;
            if (!m_visited[idx]) begin
                m_visited[idx] = 1;
                if (m_count > 0) m_count--;
            end
        end
        #1;
        chk({tag, ".cnt"}, VEC_W'(unvisited_nodes), VEC_W'(m_count));
        chk({tag, ".vec"}, prev_vector_flattened, model_vec());
    endtask

    initial begin
        int nn;
        reset = 1'b1; set_en = 1'b0; number_of_nodes = '0;
        index = '0; prev_node = '0;
        m_count = 0; m_active = 0;
        @(negedge clock);

        // Reset with ten active nodes
        step("reset10", 1, 0, 10, 0, 0);
        step("idle", 0, 0, 10, 0, 0);

        // Visit every node, strobe held two cycles: single decrement each
        for (int i = 0; i < 10; i++) begin
            int pn;
            pn = int'($urandom % 10);
            step("visit_a", 0, 1, 10, i, pn);
            step("visit_b", 0, 1, 10, i, pn);
        end

        // Revisit: prev overwritten, counter unchanged
        step("revisit3", 0, 1, 10, 3, 7);
        // Out of range indices
        step("oor12", 0, 1, 10, 12, 5);
        step("oor10", 0, 1, 10, 10, 5);

        // Reset mid-sequence together with set_en
        step("mid_a", 1, 0, 10, 0, 0);
        step("mid_b", 0, 1, 10, 1, 2);
        step("rst_en", 1, 1, 10, 4, 3);

        // prev_node equal to the unvisited marker still counts as a visit
        step("unv_visit", 0, 1, 10, 5, int'(c_UNV));
        step("unv_revisit", 0, 1, 10, 5, int'(c_UNV));
        step("unv_revisit2", 0, 1, 10, 5, 1);

        // Port change between resets must not alter the active range
        step("nn_change", 0, 1, 3, 8, 2);

        // Randomized traffic with occasional resets
        nn = 10;
        for (int k = 0; k < 400; k++) begin
            bit rst;
            rst = ($urandom % 40) == 0;
            if (($urandom % 8) == 0) nn = int'($urandom_range(0, 20));
            step("rand", rst, ($urandom % 4) != 0, nn,
                 int'($urandom % 18), int'($urandom % 256));
        end

        // Drain: visit every slot so counter reaches its floor
        step("drain_rst", 1, 0, MAX_NODES, 0, 0);
        for (int i = 0; i < MAX_NODES; i++)
            step("drain", 0, 1, MAX_NODES, i, i);
        step("drain_extra", 0, 1, MAX_NODES, 0, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule

`default_nettype wire
